// File: rtl/rect_coord_writer_pkg.sv
// -----------------------------------------------------------------------------
// rect_wr_pkg
// Shared definitions for the rectangle-overlay register producer and the
// overlay controller that consumes its writes.
//   - FSM state encoding of rect_coord_writer
//   - overlay register map constants (base address, box slot count)
//   - 32-bit word packing: x in [31:16], y in [15:0]
// Optional build macro used by the consumers of this package: RECT_WR_CLIP_EN
// -----------------------------------------------------------------------------
package rect_wr_pkg;

  localparam int RECT_BASE_ADDR = 30;
  localparam int RECT_MAX_BOXES = 5;
  localparam int RECT_COORD_W   = 16;
  localparam int RECT_ADDR_W    = 6;
  localparam int RECT_DATA_W    = 32;

  localparam int WORD_X_LSB = 16;
  localparam int WORD_Y_LSB = 0;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_WRITE   = 2'd1,
    ST_EN_HI   = 2'd2,
    ST_EN_LO   = 2'd3
  } wr_state_t;

  typedef struct packed {
    logic [RECT_COORD_W-1:0] x0;
    logic [RECT_COORD_W-1:0] y0;
    logic [RECT_COORD_W-1:0] x1;
    logic [RECT_COORD_W-1:0] y1;
  } box_t;

  function automatic logic [RECT_DATA_W-1:0] pack_xy(input logic [RECT_COORD_W-1:0] x,
                                                     input logic [RECT_COORD_W-1:0] y);
    logic [RECT_DATA_W-1:0] w;
    w = '0;
    w[WORD_X_LSB +: RECT_COORD_W] = x;
    w[WORD_Y_LSB +: RECT_COORD_W] = y;
    return w;
  endfunction

endpackage

// File: rtl/rect_coord_writer_if.sv
// -----------------------------------------------------------------------------
// rect_wr_if
// Bundles the box-input handshake, commit strobe and overlay write bus of
// rect_coord_writer.
//   master : the writer (drives o_*, receives i_*)
//   slave  : the surrounding system (post-processing stage + overlay RAM)
// Signals:
//   i_box_valid / o_box_ready   box handshake
//   i_box_x0/y0/x1/y1           box coordinates (16 bit)
//   i_frame_done                single-cycle commit strobe
//   o_addr / o_data / o_valid   overlay word write
//   o_rect_en                   reload request to the overlay
//   o_busy / o_overflow         status
// -----------------------------------------------------------------------------
interface rect_wr_if;
  import rect_wr_pkg::*;

  logic                    i_box_valid;
  logic                    o_box_ready;
  logic [RECT_COORD_W-1:0] i_box_x0;
  logic [RECT_COORD_W-1:0] i_box_y0;
  logic [RECT_COORD_W-1:0] i_box_x1;
  logic [RECT_COORD_W-1:0] i_box_y1;
  logic                    i_frame_done;
  logic [RECT_ADDR_W-1:0]  o_addr;
  logic [RECT_DATA_W-1:0]  o_data;
  logic                    o_valid;
  logic                    o_rect_en;
  logic                    o_busy;
  logic                    o_overflow;

  modport master (
    input  i_box_valid, i_box_x0, i_box_y0, i_box_x1, i_box_y1, i_frame_done,
    output o_box_ready, o_addr, o_data, o_valid, o_rect_en, o_busy, o_overflow
  );

  modport slave (
    output i_box_valid, i_box_x0, i_box_y0, i_box_x1, i_box_y1, i_frame_done,
    input  o_box_ready, o_addr, o_data, o_valid, o_rect_en, o_busy, o_overflow
  );

endinterface

// File: rtl/rect_box_clip.sv
// -----------------------------------------------------------------------------
// rect_box_clip
// Combinational clip/normalize of one detection box. Each x is saturated to
// FRAME_W-1 and each y to FRAME_H-1; afterwards the x pair and the y pair are
// swapped where needed so that x0<=x1 and y0<=y1.
// Only instantiated when RECT_WR_CLIP_EN is defined.
// Ports:
//   i_box  raw box
//   o_box  clipped, normalized box
// -----------------------------------------------------------------------------
module rect_box_clip
  import rect_wr_pkg::*;
#(
  parameter int FRAME_W = 640,
  parameter int FRAME_H = 480
) (
  input  box_t i_box,
  output box_t o_box
);

  localparam logic [RECT_COORD_W-1:0] X_MAX = RECT_COORD_W'(FRAME_W - 1);
  localparam logic [RECT_COORD_W-1:0] Y_MAX = RECT_COORD_W'(FRAME_H - 1);

  logic [RECT_COORD_W-1:0] w_x0, w_y0, w_x1, w_y1;

  always_comb begin
    w_x0 = (i_box.x0 > X_MAX) ? X_MAX : i_box.x0;
    w_x1 = (i_box.x1 > X_MAX) ? X_MAX : i_box.x1;
    w_y0 = (i_box.y0 > Y_MAX) ? Y_MAX : i_box.y0;
    w_y1 = (i_box.y1 > Y_MAX) ? Y_MAX : i_box.y1;

    o_box.x0 = (w_x0 > w_x1) ? w_x1 : w_x0;
    o_box.x1 = (w_x0 > w_x1) ? w_x0 : w_x1;
    o_box.y0 = (w_y0 > w_y1) ? w_y1 : w_y0;
    o_box.y1 = (w_y0 > w_y1) ? w_y0 : w_y1;
  end

endmodule

// File: rtl/rect_coord_writer.sv
// -----------------------------------------------------------------------------
// rect_coord_writer
// Producer side of the rectangle-overlay register interface. Collects up to
// MAX_BOXES boxes per frame, and on i_frame_done writes 2*MAX_BOXES words
// (BASE_ADDR..BASE_ADDR+2*MAX_BOXES-1, unused slots as zero) followed by an
// o_rect_en pulse of EN_HOLD cycles high and EN_HOLD cycles low.
// Ports:
//   i_clk, i_rst  clock, asynchronous active-high reset
//   bus           rect_wr_if.master (box handshake, commit, write bus, status)
// Build macro: RECT_WR_CLIP_EN -- clip/normalize boxes on capture.
//
// state      | meaning
// ST_COLLECT | accepting boxes, waiting for commit
// ST_WRITE   | emitting one overlay word per cycle
// ST_EN_HI   | o_rect_en high for EN_HOLD cycles
// ST_EN_LO   | o_rect_en low for EN_HOLD cycles, then clear frame state
// -----------------------------------------------------------------------------
module rect_coord_writer
  import rect_wr_pkg::*;
#(
  parameter int MAX_BOXES = RECT_MAX_BOXES,
  parameter int BASE_ADDR = RECT_BASE_ADDR,
  parameter int COORD_W   = 16,
  parameter int EN_HOLD   = 8,
  parameter int FRAME_W   = 640,
  parameter int FRAME_H   = 480
) (
  input  logic      i_clk,
  input  logic      i_rst,
  rect_wr_if.master bus
);

  localparam int NUM_WORDS = 2 * MAX_BOXES;
  localparam int CNT_W     = $clog2(MAX_BOXES + 1);
  localparam int SLOT_W    = (MAX_BOXES > 1) ? $clog2(MAX_BOXES) : 1;
  localparam int IDX_W     = $clog2(NUM_WORDS + 1);
  localparam int TMR_W     = $clog2(EN_HOLD);

  localparam logic [CNT_W-1:0]       CNT_FULL  = CNT_W'(MAX_BOXES);
  localparam logic [IDX_W-1:0]       IDX_LAST  = IDX_W'(NUM_WORDS);
  localparam logic [TMR_W-1:0]       TMR_LOAD  = TMR_W'(EN_HOLD - 1);
  localparam logic [RECT_ADDR_W-1:0] ADDR_BASE = RECT_ADDR_W'(BASE_ADDR);

  if (COORD_W != 16 || EN_HOLD < 4 || MAX_BOXES < 2 ||
      FRAME_W < 1 || FRAME_W > 65536 || FRAME_H < 1 || FRAME_H > 65536) begin : g_bad_param
    $error("rect_coord_writer: unsupported parameter set");
  end

  wr_state_t               r_state;
  logic [CNT_W-1:0]        r_count;
  box_t                    r_slot [MAX_BOXES];
  logic [IDX_W-1:0]        r_idx;
  logic [TMR_W-1:0]        r_tmr;
  logic                    r_pending;
  logic                    r_ready;
  logic                    r_valid;
  logic                    r_rect_en;
  logic                    r_busy;
  logic                    r_overflow;
  logic [RECT_ADDR_W-1:0]  r_addr;
  logic [RECT_DATA_W-1:0]  r_data;

  box_t                    w_raw_box;
  box_t                    w_in_box;
  box_t                    w_box;
  logic                    w_store;
  logic                    w_drop;
  logic [IDX_W-1:0]        w_idx;
  logic [IDX_W-1:0]        w_slot;
  logic [SLOT_W-1:0]       w_sel;
  logic [CNT_W-1:0]        w_used;
  logic [RECT_DATA_W-1:0]  w_word;

  assign w_raw_box = '{x0: bus.i_box_x0[COORD_W-1:0], y0: bus.i_box_y0[COORD_W-1:0],
                       x1: bus.i_box_x1[COORD_W-1:0], y1: bus.i_box_y1[COORD_W-1:0]};

`ifdef RECT_WR_CLIP_EN
  // Clipped box lands in r_cap first and reaches its slot one cycle later;
  // the word mux below forwards r_cap so a same-cycle commit still sees it.
  logic              r_cap_vld;
  logic [SLOT_W-1:0] r_cap_idx;
  box_t              r_cap_box;

  rect_box_clip #(.FRAME_W(FRAME_W), .FRAME_H(FRAME_H)) u_clip (
    .i_box (w_raw_box),
    .o_box (w_in_box)
  );
`else
  assign w_in_box = w_raw_box;
`endif

  assign w_store = (r_state == ST_COLLECT) && r_ready && bus.i_box_valid && (r_count < CNT_FULL);
  assign w_drop  = (r_state == ST_COLLECT) && r_ready && bus.i_box_valid && (r_count == CNT_FULL);

  // Word to register on this edge: word 0 at commit, word r_idx during WRITE.
  assign w_idx  = (r_state == ST_WRITE) ? r_idx : '0;
  assign w_slot = w_idx >> 1;
  assign w_sel  = SLOT_W'(w_slot);
  assign w_used = r_count + CNT_W'(w_store);

  always_comb begin
    w_box = r_slot[w_sel];
`ifdef RECT_WR_CLIP_EN
    if (r_cap_vld && (r_cap_idx == w_sel)) w_box = r_cap_box;
`endif
    // A box handshaking in the commit cycle is not in r_slot yet.
    if (w_store && (int'(w_slot) == int'(r_count))) w_box = w_in_box;

    if (int'(w_slot) >= int'(w_used)) w_word = '0;
    else if (w_idx[0])                w_word = pack_xy(w_box.x1, w_box.y1);
    else                              w_word = pack_xy(w_box.x0, w_box.y0);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_COLLECT;
      r_count    <= '0;
      r_idx      <= '0;
      r_tmr      <= '0;
      r_pending  <= 1'b0;
      r_ready    <= 1'b1;
      r_valid    <= 1'b0;
      r_rect_en  <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      for (int k = 0; k < MAX_BOXES; k++) r_slot[k] <= '0;
`ifdef RECT_WR_CLIP_EN
      r_cap_vld  <= 1'b0;
      r_cap_idx  <= '0;
      r_cap_box  <= '0;
`endif
    end else begin
`ifdef RECT_WR_CLIP_EN
      if (r_cap_vld) r_slot[r_cap_idx] <= r_cap_box;
      r_cap_vld <= 1'b0;
`endif
      if ((r_state != ST_COLLECT) && bus.i_frame_done) r_pending <= 1'b1;

      case (r_state)
        ST_COLLECT: begin
          if (w_store) begin
`ifdef RECT_WR_CLIP_EN
            r_cap_vld <= 1'b1;
            r_cap_idx <= SLOT_W'(r_count);
            r_cap_box <= w_in_box;
`else
            r_slot[SLOT_W'(r_count)] <= w_in_box;
`endif
            r_count <= r_count + 1'b1;
          end
          if (w_drop) r_overflow <= 1'b1;
          if (bus.i_frame_done) begin
            r_state <= ST_WRITE;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_valid <= 1'b1;
            r_addr  <= ADDR_BASE;
            r_data  <= w_word;
            r_idx   <= IDX_W'(1);
          end
        end

        ST_WRITE: begin
          if (r_idx == IDX_LAST) begin
            r_valid   <= 1'b0;
            r_rect_en <= 1'b1;
            r_tmr     <= TMR_LOAD;
            r_state   <= ST_EN_HI;
          end else begin
            r_valid <= 1'b1;
            r_addr  <= ADDR_BASE + RECT_ADDR_W'(r_idx);
            r_data  <= w_word;
            r_idx   <= r_idx + 1'b1;
          end
        end

        ST_EN_HI: begin
          if (r_tmr == '0) begin
            r_rect_en <= 1'b0;
            r_tmr     <= TMR_LOAD;
            r_state   <= ST_EN_LO;
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        ST_EN_LO: begin
          if (r_tmr == '0) begin
            r_count    <= '0;
            r_overflow <= 1'b0;
            for (int k = 0; k < MAX_BOXES; k++) r_slot[k] <= '0;
            if (r_pending || bus.i_frame_done) begin
              // Deferred commit: frame state is already cleared, so an
              // all-zero sequence starts straight away.
              r_pending <= 1'b0;
              r_state   <= ST_WRITE;
              r_valid   <= 1'b1;
              r_addr    <= ADDR_BASE;
              r_data    <= '0;
              r_idx     <= IDX_W'(1);
            end else begin
              r_state <= ST_COLLECT;
              r_ready <= 1'b1;
              r_busy  <= 1'b0;
            end
          end else begin
            r_tmr <= r_tmr - 1'b1;
          end
        end

        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign bus.o_box_ready = r_ready;
  assign bus.o_addr      = r_addr;
  assign bus.o_data      = r_data;
  assign bus.o_valid     = r_valid;
  assign bus.o_rect_en   = r_rect_en;
  assign bus.o_busy      = r_busy;
  assign bus.o_overflow  = r_overflow;

endmodule

// File: tb/tb_rect_coord_writer.sv
// -----------------------------------------------------------------------------
// tb_rect_coord_writer
// Directed bench for rect_coord_writer. Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
// Extra clip-path vector when built with RECT_WR_CLIP_EN.
// -----------------------------------------------------------------------------
module tb_rect_coord_writer;

  localparam int EN_HOLD   = 8;
  localparam int NUM_WORDS = 10;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;
  logic [31:0] exp_w [NUM_WORDS];

  rect_wr_if bus ();

  rect_coord_writer #(
    .MAX_BOXES (5),
    .BASE_ADDR (30),
    .COORD_W   (16),
    .EN_HOLD   (EN_HOLD),
    .FRAME_W   (640),
    .FRAME_H   (480)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic send_box(input int x0, input int y0, input int x1, input int y1, input bit fd);
    bus.i_box_valid  = 1'b1;
    bus.i_box_x0     = 16'(x0);
    bus.i_box_y0     = 16'(y0);
    bus.i_box_x1     = 16'(x1);
    bus.i_box_y1     = 16'(y1);
    bus.i_frame_done = fd;
    tick();
    bus.i_box_valid  = 1'b0;
    bus.i_frame_done = 1'b0;
  endtask

  task automatic commit();
    bus.i_frame_done = 1'b1;
    tick();
    bus.i_frame_done = 1'b0;
  endtask

  task automatic clear_exp();
    for (int n = 0; n < NUM_WORDS; n++) exp_w[n] = 32'h0;
  endtask

  task automatic chk_words(input string tag, input logic exp_ovf);
    for (int n = 0; n < NUM_WORDS; n++) begin
      if (n == 0) begin
        chk($sformatf("%s busy", tag), 32'(bus.o_busy), 32'd1);
        chk($sformatf("%s ready", tag), 32'(bus.o_box_ready), 32'd0);
        chk($sformatf("%s ovf", tag), 32'(bus.o_overflow), 32'(exp_ovf));
      end
      chk($sformatf("%s valid[%0d]", tag, n), 32'(bus.o_valid), 32'd1);
      chk($sformatf("%s addr[%0d]", tag, n), 32'(bus.o_addr), 32'(30 + n));
      chk($sformatf("%s data[%0d]", tag, n), bus.o_data, exp_w[n]);
      tick();
    end
  endtask

  task automatic chk_pulse(input string tag, input bit fd_in_hi, input logic exp_ovf);
    for (int i = 0; i < EN_HOLD; i++) begin
      chk($sformatf("%s en_hi[%0d]", tag, i), 32'(bus.o_rect_en), 32'd1);
      chk($sformatf("%s hi_valid[%0d]", tag, i), 32'(bus.o_valid), 32'd0);
      if (fd_in_hi && (i == 2 || i == 5)) bus.i_frame_done = 1'b1;
      tick();
      bus.i_frame_done = 1'b0;
    end
    for (int i = 0; i < EN_HOLD; i++) begin
      chk($sformatf("%s en_lo[%0d]", tag, i), 32'(bus.o_rect_en), 32'd0);
      chk($sformatf("%s lo_valid[%0d]", tag, i), 32'(bus.o_valid), 32'd0);
      if (i == EN_HOLD - 1) chk($sformatf("%s lo_ovf", tag), 32'(bus.o_overflow), 32'(exp_ovf));
      tick();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk($sformatf("%s idle busy", tag), 32'(bus.o_busy), 32'd0);
    chk($sformatf("%s idle ready", tag), 32'(bus.o_box_ready), 32'd1);
    chk($sformatf("%s idle valid", tag), 32'(bus.o_valid), 32'd0);
    chk($sformatf("%s idle en", tag), 32'(bus.o_rect_en), 32'd0);
    chk($sformatf("%s idle ovf", tag), 32'(bus.o_overflow), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.i_box_valid  = 1'b0;
    bus.i_box_x0     = '0;
    bus.i_box_y0     = '0;
    bus.i_box_x1     = '0;
    bus.i_box_y1     = '0;
    bus.i_frame_done = 1'b0;
    tick();
    tick();

    // reset values
    chk("rst ready", 32'(bus.o_box_ready), 32'd1);
    chk("rst valid", 32'(bus.o_valid), 32'd0);
    chk("rst addr", 32'(bus.o_addr), 32'd0);
    chk("rst data", bus.o_data, 32'd0);
    chk("rst en", 32'(bus.o_rect_en), 32'd0);
    chk("rst busy", 32'(bus.o_busy), 32'd0);
    chk("rst ovf", 32'(bus.o_overflow), 32'd0);
    rst = 1'b0;
    tick();

    // two boxes, second one handshakes in the commit cycle
    clear_exp();
    exp_w[0] = 32'h000A0014;
    exp_w[1] = 32'h006400C8;
    exp_w[2] = 32'h012C0028;
    exp_w[3] = 32'h015E005A;
    send_box(10, 20, 100, 200, 1'b0);
    send_box(300, 40, 350, 90, 1'b1);
    chk_words("two", 1'b0);
    chk_pulse("two", 1'b0, 1'b0);
    chk_idle("two");

    // six boxes: sixth dropped, overflow sticky through EN_LO
    clear_exp();
    for (int k = 0; k < 5; k++) begin
      exp_w[2*k]   = {16'(k + 1), 16'(k + 2)};
      exp_w[2*k+1] = {16'(k + 3), 16'(k + 4)};
    end
    for (int i = 1; i <= 5; i++) send_box(i, i + 1, i + 2, i + 3, 1'b0);
    chk("six ovf before drop", 32'(bus.o_overflow), 32'd0);
    chk("six ready at full", 32'(bus.o_box_ready), 32'd1);
    send_box(6, 7, 8, 9, 1'b0);
    chk("six ovf after drop", 32'(bus.o_overflow), 32'd1);
    commit();
    chk_words("six", 1'b1);
    chk_pulse("six", 1'b0, 1'b1);
    chk_idle("six");

    // empty commit clears the display
    clear_exp();
    commit();
    chk_words("zero", 1'b0);
    chk_pulse("zero", 1'b0, 1'b0);
    chk_idle("zero");

    // commit strobes during EN_HI: exactly one extra all-zero sequence
    clear_exp();
    exp_w[0] = 32'h00010002;
    exp_w[1] = 32'h00030004;
    send_box(1, 2, 3, 4, 1'b1);
    chk_words("pend1", 1'b0);
    chk_pulse("pend1", 1'b1, 1'b0);
    clear_exp();
    chk_words("pend2", 1'b0);
    chk_pulse("pend2", 1'b0, 1'b0);
    chk_idle("pend2");
    for (int i = 0; i < 6; i++) tick();
    chk("pend no third valid", 32'(bus.o_valid), 32'd0);
    chk("pend no third busy", 32'(bus.o_busy), 32'd0);

    // reset on the 4th write beat
    send_box(1, 2, 3, 4, 1'b1);
    chk("rstw beat0", bus.o_data, 32'h00010002);
    tick();
    chk("rstw beat1", bus.o_data, 32'h00030004);
    tick();
    chk("rstw beat2 addr", 32'(bus.o_addr), 32'd32);
    tick();
    chk("rstw beat3 valid", 32'(bus.o_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw valid", 32'(bus.o_valid), 32'd0);
    chk("rstw en", 32'(bus.o_rect_en), 32'd0);
    chk("rstw addr", 32'(bus.o_addr), 32'd0);
    chk("rstw ready", 32'(bus.o_box_ready), 32'd1);
    chk("rstw busy", 32'(bus.o_busy), 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rstw quiet[%0d]", i), 32'(bus.o_valid), 32'd0);
    end
    clear_exp();
    commit();
    chk_words("post", 1'b0);
    chk_pulse("post", 1'b0, 1'b0);
    chk_idle("post");

`ifdef RECT_WR_CLIP_EN
    // clipped and normalized on capture, same-cycle commit
    clear_exp();
    exp_w[0] = 32'h0005000A;
    exp_w[1] = 32'h027F01DF;
    send_box(700, 10, 5, 500, 1'b1);
    chk_words("clip", 1'b0);
    chk_pulse("clip", 1'b0, 1'b0);
    chk_idle("clip");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
